md_lsu: RTL and testbench

Load/store initiator that drives the data memory's word port (ADR, DIN, W, R, DOUT) on behalf of the CPU datapath. It accepts one byte-addressed load or store request at a time over a valid/ready handshake. It converts the request into word-indexed memory strobes, performing read-modify-write for byte and halfword stores and sign or zero extension for loads. It returns one response pulse per request, with an error flag for misaligned or out-of-range accesses.

---
 rtl/md_lsu.sv | 180 ++++++++++++++++++
 tb/tb_md_lsu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_lsu.sv
// md_lsu - load/store initiator for the data memory word port.
//
// Accepts one byte-addressed load or store at a time over a valid/ready
// handshake and turns it into word-indexed memory strobes. Byte and
// halfword stores are done as read-modify-write; loads are sign or zero
// extended. Every accepted request gets exactly one response pulse.
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   REQ_VALID / REQ_READY      request handshake (READY high only in IDLE)
//   REQ_WE, REQ_SIZE, REQ_UNS  store flag, access size, zero-extend flag
//   REQ_ADDR, REQ_WDATA        byte address, right-aligned store data
//   RSP_VALID, RSP_RDATA,      one-cycle response pulse, extended load
//   RSP_ERR                    data (0 for stores/errors), reject flag
//   ADR, DIN, W, R             memory word index, write word, strobes
//   DOUT                       memory read word (combinational)

module md_lsu #(
    parameter int DEPTH = 128,
    parameter int IDX_W = 7
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNS,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] ADR,
    output logic [31:0] DIN,
    output logic        W,
    output logic        R,
    input  logic [31:0] DOUT
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t state;
    state_t state_next;

    // Only the bits that address a legal word and its lanes are kept;
    // the range check is made on the live request address at accept.
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             uns_q;
    logic             err_q;

    logic             accept;
    logic             req_err;
    logic [31:0]      merged;
    logic [31:0]      load_data;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    assign accept = REQ_VALID && (state == IDLE);

    assign req_err = (REQ_SIZE == 2'b11)
                  || ((REQ_SIZE == 2'b01) && REQ_ADDR[0])
                  || ((REQ_SIZE == 2'b10) && (REQ_ADDR[1:0] != 2'b00))
                  || (REQ_ADDR[31:2] >= 30'(DEPTH));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Word stores skip the read; every other legal
    // access reads first (loads to return data, sub-word stores to merge).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (REQ_WE && (REQ_SIZE == 2'b10))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture at accept, and read-word capture at the end of RD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= REQ_ADDR[IDX_W+1:0];
                wdata_q <= REQ_WDATA;
                size_q  <= REQ_SIZE;
                we_q    <= REQ_WE;
                uns_q   <= REQ_UNS;
                err_q   <= req_err;
            end
            if (state == RD) begin
                word_q <= DOUT;
            end
        end
    end

    // Store word: the captured read word with only the addressed
    // little-endian lane replaced; a full word store uses wdata as is.
    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
        half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, byte_sel}
                                       : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = uns_q ? {16'b0, half_sel}
                                       : {{16{half_sel[15]}}, half_sel};
            default: load_data = word_q;
        endcase
    end

    // Outputs decoded from registered state only, so strobes drop the
    // moment reset forces the state back to IDLE.
    always_comb begin
        REQ_READY = (state == IDLE);
        RSP_VALID = 1'b0;
        RSP_RDATA = '0;
        RSP_ERR   = 1'b0;
        ADR       = '0;
        DIN       = '0;
        W         = 1'b0;
        R         = 1'b0;
        case (state)
            RD: begin
                R   = 1'b1;
                ADR = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
            end
            WR: begin
                W   = 1'b1;
                ADR = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
                DIN = merged;
            end
            RESP: begin
                RSP_VALID = 1'b1;
                RSP_ERR   = err_q;
                RSP_RDATA = (err_q || we_q) ? 32'b0 : load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md_lsu.sv
// tb_md_lsu - directed, scoreboarded bench for md_lsu with a behavioural
// 128-word data memory attached to the word port.

module tb_md_lsu;

    logic        CLK;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_UNS;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] ADR;
    logic [31:0] DIN;
    logic        W;
    logic        R;
    logic [31:0] DOUT;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [128];
    logic        poke_en;
    logic [6:0]  poke_idx;
    logic [31:0] poke_val;

    logic [32:0] sb [$];
    int          w_cnt = 0;
    int          r_cnt = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_w_adr;
    logic [31:0] last_w_din;

    md_lsu #(.DEPTH(128), .IDX_W(7)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_SIZE  (REQ_SIZE),
        .REQ_UNS   (REQ_UNS),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .ADR       (ADR),
        .DIN       (DIN),
        .W         (W),
        .R         (R),
        .DOUT      (DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural data memory: combinational read, write on the rising edge.
    assign DOUT = mem[ADR[6:0]];

    always @(posedge CLK) begin
        if (poke_en)
            mem[poke_idx] <= poke_val;
        else if (W)
            mem[ADR[6:0]] <= DIN;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: strobe bookkeeping, W/R exclusivity, and the scoreboard pop.
    always @(negedge CLK) begin
        if (W) begin
            w_cnt++;
            last_w_adr = ADR;
            last_w_din = DIN;
        end
        if (R) r_cnt++;
        if (REQ_VALID && REQ_READY && RST_N) acc_cnt++;
        checkOutput("w_r_exclusive", {31'b0, W & R}, 32'd0);
        if (RSP_VALID) begin
            rsp_cnt++;
            checkOutput("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                checkOutput("rsp_rdata", RSP_RDATA, e[32:1]);
                checkOutput("rsp_err", {31'b0, RSP_ERR}, {31'b0, e[0]});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic poke(input logic [6:0] idx, input logic [31:0] val);
        @(negedge CLK);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        @(posedge CLK);
        #1 poke_en = 1'b0;
    endtask

    // Drive one request, then check latency and strobe counts; data and
    // error flag are checked by the monitor against the scoreboard.
    task automatic applyStimulus(input string tag, input logic we,
                                 input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_lat,
                                 input int exp_r, input int exp_w);
        int r0, w0, lat;
        bit got;
        @(negedge CLK);
        checkOutput({tag, "_ready"}, {31'b0, REQ_READY}, 32'd1);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_SIZE  = size;
        REQ_UNS   = uns;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        sb.push_back({exp_rdata, exp_err});
        r0 = r_cnt;
        w0 = w_cnt;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        lat = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if (RSP_VALID) got = 1;
        end
        checkOutput({tag, "_rsp_seen"}, {31'b0, got}, 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_r_cycles"}, 32'(r_cnt - r0), 32'(exp_r));
        checkOutput({tag, "_w_cycles"}, 32'(w_cnt - w0), 32'(exp_w));
    endtask

    initial begin
        int  acc0, rsp0, seen;
        bit  outstanding;
        poke_en   = 1'b0;
        poke_idx  = '0;
        poke_val  = '0;
        RST_N     = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_SIZE  = 2'b00;
        REQ_UNS   = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge CLK);
        checkOutput("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        checkOutput("rst_rsp_rdata", RSP_RDATA, 32'd0);
        checkOutput("rst_rsp_err", {31'b0, RSP_ERR}, 32'd0);
        checkOutput("rst_adr", ADR, 32'd0);
        checkOutput("rst_din", DIN, 32'd0);
        checkOutput("rst_w", {31'b0, W}, 32'd0);
        checkOutput("rst_r", {31'b0, R}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("rst_ready", {31'b0, REQ_READY}, 32'd1);

        // Word store then load
        applyStimulus("st_word", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
                      32'h0, 0, 2, 0, 1);
        checkOutput("st_word_adr", last_w_adr, 32'd4);
        checkOutput("st_word_din", last_w_din, 32'hDEADBEEF);
        checkOutput("st_word_mem", mem[4], 32'hDEADBEEF);
        applyStimulus("ld_word", 0, 2'b10, 0, 32'h10, 32'h0,
                      32'hDEADBEEF, 0, 2, 1, 0);

        // Byte store read-modify-write; upper store-data bits must be ignored
        poke(7'd4, 32'h11223344);
        applyStimulus("st_byte", 1, 2'b00, 0, 32'h12, 32'h123456AB,
                      32'h0, 0, 3, 1, 1);
        checkOutput("st_byte_adr", last_w_adr, 32'd4);
        checkOutput("st_byte_din", last_w_din, 32'h11AB3344);
        checkOutput("st_byte_mem", mem[4], 32'h11AB3344);
        applyStimulus("ld_byte_s", 0, 2'b00, 0, 32'h12, 32'h0,
                      32'hFFFFFFAB, 0, 2, 1, 0);
        applyStimulus("ld_byte_u", 0, 2'b00, 1, 32'h12, 32'h0,
                      32'h000000AB, 0, 2, 1, 0);

        // Halfword store RMW into the upper half
        applyStimulus("st_half", 1, 2'b01, 0, 32'h12, 32'hFFFF5A5A,
                      32'h0, 0, 3, 1, 1);
        checkOutput("st_half_din", last_w_din, 32'h5A5A3344);

        // Halfword and byte loads
        poke(7'd4, 32'h80017FFE);
        applyStimulus("ld_half_hi_s", 0, 2'b01, 0, 32'h12, 32'h0,
                      32'hFFFF8001, 0, 2, 1, 0);
        applyStimulus("ld_half_lo_s", 0, 2'b01, 0, 32'h10, 32'h0,
                      32'h00007FFE, 0, 2, 1, 0);
        applyStimulus("ld_half_hi_u", 0, 2'b01, 1, 32'h12, 32'h0,
                      32'h00008001, 0, 2, 1, 0);
        applyStimulus("ld_byte3_u", 0, 2'b00, 1, 32'h13, 32'h0,
                      32'h00000080, 0, 2, 1, 0);

        // Errors: no strobes, response one cycle after accept
        applyStimulus("err_word_mis", 0, 2'b10, 0, 32'h11, 32'h0,
                      32'h0, 1, 1, 0, 0);
        applyStimulus("err_half_mis", 0, 2'b01, 0, 32'h13, 32'h0,
                      32'h0, 1, 1, 0, 0);
        applyStimulus("err_size11", 0, 2'b11, 0, 32'h0, 32'h0,
                      32'h0, 1, 1, 0, 0);
        applyStimulus("err_range", 0, 2'b10, 0, 32'h200, 32'h0,
                      32'h0, 1, 1, 0, 0);
        applyStimulus("err_st_range", 1, 2'b10, 0, 32'h200, 32'h12345678,
                      32'h0, 1, 1, 0, 0);
        checkOutput("err_st_mem0", mem[0], 32'h0);
        poke(7'd127, 32'hCAFEF00D);
        applyStimulus("ld_last_word", 0, 2'b10, 0, 32'h1FC, 32'h0,
                      32'hCAFEF00D, 0, 2, 1, 0);

        // Handshake: REQ_VALID held high across two word loads
        poke(7'd10, 32'hA5A5A5A5);
        poke(7'd11, 32'h5A5A5A5A);
        @(negedge CLK);
        acc0 = acc_cnt;
        rsp0 = rsp_cnt;
        sb.push_back({32'hA5A5A5A5, 1'b0});
        sb.push_back({32'h5A5A5A5A, 1'b0});
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_SIZE  = 2'b10;
        REQ_UNS   = 1'b0;
        REQ_ADDR  = 32'h28;
        outstanding = 1;
        @(posedge CLK);
        #1 REQ_ADDR = 32'h2C;
        seen = 0;
        for (int i = 0; i < 12 && seen < 2; i++) begin
            @(negedge CLK);
            if (outstanding)
                checkOutput("hs_ready_low", {31'b0, REQ_READY}, 32'd0);
            if (RSP_VALID) begin
                seen++;
                outstanding = 0;
            end
            if (REQ_VALID && REQ_READY) outstanding = 1;
        end
        REQ_VALID = 1'b0;
        checkOutput("hs_responses", 32'(seen), 32'd2);
        @(negedge CLK);
        checkOutput("hs_accepts", 32'(acc_cnt - acc0), 32'd2);
        checkOutput("hs_rsp_cnt", 32'(rsp_cnt - rsp0), 32'd2);

        // Reset during the RD cycle of a byte store
        poke(7'd5, 32'h55667788);
        @(negedge CLK);
        rsp0 = rsp_cnt;
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b1;
        REQ_SIZE  = 2'b00;
        REQ_ADDR  = 32'h14;
        REQ_WDATA = 32'h000000CC;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        checkOutput("rmid_r_before", {31'b0, R}, 32'd1);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("rmid_r_drop", {31'b0, R}, 32'd0);
        checkOutput("rmid_w_drop", {31'b0, W}, 32'd0);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("rmid_w_held", {31'b0, W}, 32'd0);
        end
        checkOutput("rmid_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
        checkOutput("rmid_mem", mem[5], 32'h55667788);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("rmid_ready", {31'b0, REQ_READY}, 32'd1);
        checkOutput("rmid_no_rsp_after", 32'(rsp_cnt - rsp0), 32'd0);
        applyStimulus("post_rst_ld", 0, 2'b10, 0, 32'h14, 32'h0,
                      32'h55667788, 0, 2, 1, 0);
        applyStimulus("post_rst_st", 1, 2'b00, 0, 32'h14, 32'h000000CC,
                      32'h0, 0, 3, 1, 1);
        checkOutput("post_rst_mem", mem[5], 32'h556677CC);

        repeat (2) @(negedge CLK);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
